ltc2324_capture_ctrl: RTL

//  Sequences the LTC2324 quad-ADC sampler for DMA capture. Drives its sample_en, collects each
//  4-channel result on its valid strobe and packs enabled channels into 32-bit AXI-Stream words.

---
 rtl/ltc2324_cap_pkg.sv | 30 +++
 rtl/ltc2324_capture_ctrl_if.sv | 13 +
 rtl/ltc2324_axis_fifo.sv | 64 ++++++
 rtl/ltc2324_capture_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ltc2324_cap_pkg.sv
// Shared types and constants for the LTC2324 capture controller.
package ltc2324_cap_pkg;

    localparam int unsigned AXIS_W   = 32;
    localparam int unsigned HW_W     = 16;
    localparam int unsigned NUM_CH   = 4;
    localparam int unsigned CH_IDX_W = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } cap_state_e;

    typedef struct packed {
        logic              last;
        logic [AXIS_W-1:0] data;
    } axis_word_t;

    // Index of the lowest set bit; channel order ch1 -> ch4.
    function automatic logic [CH_IDX_W-1:0] first_ch(input logic [NUM_CH-1:0] m);
        logic [CH_IDX_W-1:0] idx;
        idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i]) idx = CH_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/ltc2324_capture_ctrl_if.sv
// AXI-Stream output bundle of the capture controller.
interface ltc2324_capture_ctrl_if;
    import ltc2324_cap_pkg::*;

    logic [AXIS_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/ltc2324_axis_fifo.sv
// First-word-fall-through FIFO holding {tlast, tdata}; pushes while full are ignored.
module ltc2324_axis_fifo
    import ltc2324_cap_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  axis_word_t wdata_i,
    input  logic       pop_i,
    output axis_word_t rdata_o,
    output logic       full_o,
    output logic       empty_o,
    output logic       empty_nxt_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    axis_word_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full_q, empty_q;
    logic             do_push, do_pop;

    assign do_push = push_i & ~full_q;
    assign do_pop  = pop_i & ~empty_q;

    always_comb begin
        cnt_d = cnt_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            mem_q    <= '{default: '0};
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == CNT_W'(DEPTH));
            empty_q <= (cnt_d == '0);
        end
    end

    assign rdata_o     = mem_q[rd_ptr_q];
    assign full_o      = full_q;
    assign empty_o     = empty_q;
    assign empty_nxt_c = (cnt_d == '0);

endmodule

// File: rtl/ltc2324_capture_ctrl.sv
// LTC2324 capture sequencer: drives sample_en, serializes enabled channels into
// 32-bit AXIS words framed by frame_len sample sets.
module ltc2324_capture_ctrl
    import ltc2324_cap_pkg::*;
#(
    parameter int unsigned FRAME_LEN_W = 16,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic                   stop_i,
    input  logic                   continuous_i,
    input  logic [FRAME_LEN_W-1:0] frame_len_i,
    input  logic [NUM_CH-1:0]      ch_mask_i,
    output logic                   sample_en_o,
    input  logic                   adc_valid_i,
    input  logic [HW_W-1:0]        adc_ch1_i,
    input  logic [HW_W-1:0]        adc_ch2_i,
    input  logic [HW_W-1:0]        adc_ch3_i,
    input  logic [HW_W-1:0]        adc_ch4_i,
    ltc2324_capture_ctrl_if.master m_axis,
    output logic                   busy_o,
    output logic                   frame_done_o,
    output logic                   overflow_o
);

    cap_state_e                    state_q, state_d;
    logic [FRAME_LEN_W-1:0]        len_q, len_d, count_q, count_d;
    logic [NUM_CH-1:0]             mask_q, mask_d, rem_q, rem_d;
    logic                          cont_q, cont_d;
    logic                          stop_pend_q, stop_pend_d;
    logic [NUM_CH-1:0][HW_W-1:0]   hold_q, hold_d;
    logic                          last_set_q, last_set_d;
    logic [HW_W-1:0]               half_q, half_d;
    logic                          half_vld_q, half_vld_d;
    logic                          pend_last_q, pend_last_d;
    logic                          overflow_q, overflow_d;
    logic                          frame_done_q, frame_done_d;
    logic                          sample_en_q, sample_en_d;
    logic                          busy_q, busy_d;

    logic [CH_IDX_W-1:0]           ch_idx_c;
    logic [HW_W-1:0]               hw_c;
    logic [NUM_CH-1:0]             rem_after_c;
    logic                          ser_busy_c, final_hw_c;
    logic                          ser_push_c;
    axis_word_t                    ser_word_c;
    logic                          fifo_push_c;
    axis_word_t                    fifo_wdata_c, fifo_rdata;
    logic                          fifo_full, fifo_empty, fifo_empty_nxt;

    assign ser_busy_c  = (rem_q != '0);
    assign ch_idx_c    = first_ch(rem_q);
    assign hw_c        = hold_q[ch_idx_c];
    assign rem_after_c = rem_q & ~(NUM_CH'(1) << ch_idx_c);
    assign final_hw_c  = ser_busy_c & last_set_q & (rem_after_c == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            count_q      <= '0;
            mask_q       <= '0;
            rem_q        <= '0;
            cont_q       <= 1'b0;
            stop_pend_q  <= 1'b0;
            hold_q       <= '0;
            last_set_q   <= 1'b0;
            half_q       <= '0;
            half_vld_q   <= 1'b0;
            pend_last_q  <= 1'b0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
            sample_en_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            count_q      <= count_d;
            mask_q       <= mask_d;
            rem_q        <= rem_d;
            cont_q       <= cont_d;
            stop_pend_q  <= stop_pend_d;
            hold_q       <= hold_d;
            last_set_q   <= last_set_d;
            half_q       <= half_d;
            half_vld_q   <= half_vld_d;
            pend_last_q  <= pend_last_d;
            overflow_q   <= overflow_d;
            frame_done_q <= frame_done_d;
            sample_en_q  <= sample_en_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        count_d      = count_q;
        mask_d       = mask_q;
        rem_d        = rem_q;
        cont_d       = cont_q;
        stop_pend_d  = stop_pend_q | stop_i;
        hold_d       = hold_q;
        last_set_d   = last_set_q;
        half_d       = half_q;
        half_vld_d   = half_vld_q;
        pend_last_d  = pend_last_q;
        overflow_d   = overflow_q;
        frame_done_d = 1'b0;
        ser_push_c   = 1'b0;
        ser_word_c   = '0;
        fifo_push_c  = 1'b0;
        fifo_wdata_c = '0;

        // Serializer and packer: one halfword per cycle while channels remain.
        if (ser_busy_c) begin
            rem_d = rem_after_c;
            if (final_hw_c) last_set_d = 1'b0;
            if (half_vld_q) begin
                ser_push_c = 1'b1;
                ser_word_c = '{last: final_hw_c, data: {hw_c, half_q}};
                half_vld_d = 1'b0;
            end else if (final_hw_c) begin
                ser_push_c = 1'b1;
                ser_word_c = '{last: 1'b1, data: {HW_W'(0), hw_c}};
            end else begin
                half_d     = hw_c;
                half_vld_d = 1'b1;
            end
        end

        // A dropped tlast word hands its frame marker to the next word that fits.
        if (ser_push_c) begin
            if (fifo_full) begin
                overflow_d = 1'b1;
                if (ser_word_c.last) pend_last_d = 1'b1;
            end else begin
                fifo_push_c  = 1'b1;
                fifo_wdata_c = '{last: ser_word_c.last | pend_last_q, data: ser_word_c.data};
                frame_done_d = ser_word_c.last | pend_last_q;
                pend_last_d  = 1'b0;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start_i && (ch_mask_i != '0) && (frame_len_i != '0)) begin
                    len_d      = frame_len_i;
                    mask_d     = ch_mask_i;
                    cont_d     = continuous_i;
                    count_d    = '0;
                    overflow_d = 1'b0;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                if (adc_valid_i) begin
                    if (ser_busy_c) begin
                        overflow_d = 1'b1;
                    end else begin
                        hold_d = {adc_ch4_i, adc_ch3_i, adc_ch2_i, adc_ch1_i};
                        rem_d  = mask_q;
                        if ((count_q + FRAME_LEN_W'(1)) == len_q) begin
                            count_d    = '0;
                            last_set_d = 1'b1;
                            state_d    = S_FLUSH;
                        end else begin
                            count_d = count_q + FRAME_LEN_W'(1);
                        end
                    end
                end
            end
            S_FLUSH: begin
                if (!ser_busy_c) begin
                    state_d = (cont_q && !stop_pend_d) ? S_RUN : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if ((state_d == S_IDLE) && (state_q != S_IDLE)) stop_pend_d = 1'b0;

        sample_en_d = (state_d == S_RUN) ||
                      ((state_d == S_FLUSH) && cont_d && !stop_pend_d);
        busy_d      = (state_d != S_IDLE) || !fifo_empty_nxt;
    end

    ltc2324_axis_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push_c),
        .wdata_i     (fifo_wdata_c),
        .pop_i       (m_axis.tready),
        .rdata_o     (fifo_rdata),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .empty_nxt_c (fifo_empty_nxt)
    );

    assign m_axis.tdata  = fifo_rdata.data;
    assign m_axis.tlast  = fifo_rdata.last;
    assign m_axis.tvalid = ~fifo_empty;

    assign sample_en_o  = sample_en_q;
    assign busy_o       = busy_q;
    assign frame_done_o = frame_done_q;
    assign overflow_o   = overflow_q;

endmodule
